if_fetch_ctrl: RTL

//  Fetch-side consumer of the EX-stage jump/branch resolution (flush + PC-select).

---
 rtl/if_pkg.sv | 32 +++
 rtl/if_pc_next.sv | 48 ++++
 rtl/if_fetch_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch controller:
//   - PC-select encodings driven by the EX-stage branch/jump resolver
//   - fetch FSM state type
//   - default reset PC and the bubble instruction (addi x0,x0,0)
// No ports; imported by if_pc_next and if_fetch_ctrl.
// -----------------------------------------------------------------------------
package if_pkg;

    // PC-select encodings coming from EX. RSV behaves like SEQ.
    localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
    localparam logic [1:0] PC_SEL_BR   = 2'b01;
    localparam logic [1:0] PC_SEL_JALR = 2'b10;
    localparam logic [1:0] PC_SEL_RSV  = 2'b11;

    // Bubble instruction and default reset vector
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    // Fetch FSM:
    //   ST_FETCH - request at PC, response expected this cycle
    //   ST_WAIT  - memory not ready yet, request held at PC
    //   ST_KILL  - redirect arrived while a request was outstanding; the old
    //              request is kept on the bus until it completes, then dropped
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_pc_next.sv
// -----------------------------------------------------------------------------
// if_pc_next
// Combinational next-PC selection for the fetch controller.
// Ports:
//   pc_i          current PC
//   flush_i       EX-stage redirect request
//   pc_sel_i      PC-select encoding (see if_pkg)
//   br_target_i   branch/JAL target
//   jalr_target_i JALR target (bit 0 cleared here)
//   pc_seq_o      pc_i + 4 (wraps modulo 2^XLEN)
//   target_o      redirect target with bits [1:0] forced to zero
//   redirect_o    flush_i with a branch or JALR select
//   misalign_o    redirect whose target was not word aligned
// -----------------------------------------------------------------------------
module if_pc_next
    import if_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    input  logic [1:0]      pc_sel_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic [XLEN-1:0] jalr_target_i,
    output logic [XLEN-1:0] pc_seq_o,
    output logic [XLEN-1:0] target_o,
    output logic            redirect_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] raw_target;

    // Pick the raw target first so that the misalignment check sees the
    // JALR address after its architectural bit-0 clear, then word-align it
    // for the PC register.
    always_comb begin
        raw_target = br_target_i;
        if (pc_sel_i == PC_SEL_JALR) begin
            raw_target = {jalr_target_i[XLEN-1:1], 1'b0};
        end
        redirect_o = flush_i & ((pc_sel_i == PC_SEL_BR) | (pc_sel_i == PC_SEL_JALR));
        misalign_o = redirect_o & (raw_target[1:0] != 2'b00);
        target_o   = {raw_target[XLEN-1:2], 2'b00};
    end

    assign pc_seq_o = pc_i + XLEN'(4);

endmodule

// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
// Fetch stage: owns the PC, issues instruction-memory requests with a ready
// handshake, loads the IF/ID register and applies EX-stage redirects by
// loading the new PC and squashing wrong-path fetches with a NOP bubble.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush_i, pc_sel_i          EX redirect request and PC-select
//   br_target_i, jalr_target_i redirect targets
//   stall_i                    hazard stall, freezes PC and IF/ID
//   imem_req_o, imem_addr_o    fetch request / address
//   imem_ready_i, imem_rdata_i same-cycle response
//   ifid_pc_o, ifid_pc4_o      PC and PC+4 of the IF/ID instruction
//   ifid_instr_o, ifid_valid_o IF/ID instruction and valid flag
//   misalign_o                 one-cycle pulse on a misaligned redirect
// -----------------------------------------------------------------------------
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic [1:0]      pc_sel_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic [XLEN-1:0] jalr_target_i,
    input  logic            stall_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic [31:0]     imem_rdata_i,
    output logic [XLEN-1:0] ifid_pc_o,
    output logic [XLEN-1:0] ifid_pc4_o,
    output logic [31:0]     ifid_instr_o,
    output logic            ifid_valid_o,
    output logic            misalign_o
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] kill_addr_q;
    logic [XLEN-1:0] ifid_pc_q;
    logic [XLEN-1:0] ifid_pc4_q;
    logic [31:0]     ifid_instr_q;
    logic            ifid_valid_q;
    logic            misalign_q;

    logic [XLEN-1:0] pc_seq_d;
    logic [XLEN-1:0] target_d;
    logic            redirect_d;
    logic            misalign_d;

    if_pc_next #(
        .XLEN (XLEN)
    ) u_pc_next (
        .pc_i          (pc_q),
        .flush_i       (flush_i),
        .pc_sel_i      (pc_sel_i),
        .br_target_i   (br_target_i),
        .jalr_target_i (jalr_target_i),
        .pc_seq_o      (pc_seq_d),
        .target_o      (target_d),
        .redirect_o    (redirect_d),
        .misalign_o    (misalign_d)
    );

    // Every state requests continuously, so the request simply follows reset.
    // In KILL the PC already holds the redirect target while the bus must keep
    // presenting the abandoned address until memory completes it.
    assign imem_req_o   = rst_n;
    assign imem_addr_o  = (state_q == ST_KILL) ? kill_addr_q : pc_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;
    assign misalign_o   = misalign_q;

    // Fetch FSM together with the PC and IF/ID registers.
    // FETCH and WAIT behave identically except for where a redirect goes: a
    // redirect in WAIT with the response still missing must wait it out in
    // KILL. Priority is redirect, then a plain squash (flush with a sequential
    // select), then stall, then normal capture. A bubble only replaces the
    // instruction and valid flag; the IF/ID PC fields keep their old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            kill_addr_q  <= '0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
            case (state_q)
                ST_FETCH, ST_WAIT: begin
                    if (redirect_d) begin
                        pc_q         <= target_d;
                        ifid_instr_q <= NOP_INSTR;
                        ifid_valid_q <= 1'b0;
                        if ((state_q == ST_WAIT) && !imem_ready_i) begin
                            state_q     <= ST_KILL;
                            kill_addr_q <= pc_q;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end else if (flush_i) begin
                        ifid_instr_q <= NOP_INSTR;
                        ifid_valid_q <= 1'b0;
                        if (!stall_i) begin
                            if (imem_ready_i) begin
                                pc_q    <= pc_seq_d;
                                state_q <= ST_FETCH;
                            end else begin
                                state_q <= ST_WAIT;
                            end
                        end
                    end else if (stall_i) begin
                        state_q <= state_q;
                    end else if (imem_ready_i) begin
                        ifid_pc_q    <= pc_q;
                        ifid_pc4_q   <= pc_seq_d;
                        ifid_instr_q <= imem_rdata_i;
                        ifid_valid_q <= 1'b1;
                        pc_q         <= pc_seq_d;
                        state_q      <= ST_FETCH;
                    end else begin
                        ifid_instr_q <= NOP_INSTR;
                        ifid_valid_q <= 1'b0;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_KILL: begin
                    ifid_instr_q <= NOP_INSTR;
                    ifid_valid_q <= 1'b0;
                    if (redirect_d) begin
                        pc_q <= target_d;
                    end
                    if (imem_ready_i) begin
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

endmodule
